clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_ctrl.sv | 109 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Enable controller for an integrated clock-gate cell: gates the downstream clock after a
// programmable idle run, restarts it on activity or wake request, and acknowledges after settling.
module clk_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_auto_en,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic              busy,
    input  logic              wake_req,
    input  logic              force_on,
    input  logic              test_mode,
    output logic              gate_en,
    output logic              gate_se,
    output logic              gated,
    output logic              wake_ack,
    output logic [1:0]        dbg_state,
    output logic [IDLE_W-1:0] dbg_idle_cnt
);

    localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [WCW-1:0]    wake_cnt, wake_cnt_nxt;
    logic              wake_ack_nxt;
    logic              idle;
    logic              activity;

    assign idle = !busy && !wake_req && !force_on && !test_mode && cfg_auto_en &&
                  (cfg_idle_thresh != '0);
    assign activity = busy || wake_req || force_on || test_mode;

    // Scan enable must follow test_mode without a register in between.
    assign gate_se      = test_mode;
    assign dbg_state    = state;
    assign dbg_idle_cnt = idle_cnt;

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        wake_cnt_nxt = wake_cnt;
        wake_ack_nxt = 1'b0;
        unique case (state)
            RUN: begin
                wake_cnt_nxt = '0;
                // >= so a threshold lowered below the running count gates on the next idle cycle
                if (!idle) begin
                    idle_cnt_nxt = '0;
                end else if (idle_cnt >= cfg_idle_thresh - IDLE_W'(1)) begin
                    state_nxt    = GATED;
                    idle_cnt_nxt = '0;
                end else if (idle_cnt != '1) begin
                    idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                end
                if (wake_req && !wake_ack) begin
                    wake_ack_nxt = 1'b1;
                end
            end
            GATED: begin
                if (activity) begin
                    state_nxt    = WAKE;
                    wake_cnt_nxt = '0;
                end
            end
            WAKE: begin
                // Settle time always runs to completion; inputs only matter on the last count.
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt    = RUN;
                    wake_cnt_nxt = '0;
                    wake_ack_nxt = wake_req;
                end else begin
                    wake_cnt_nxt = wake_cnt + WCW'(1);
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            gate_en  <= 1'b1;
            gated    <= 1'b0;
            wake_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            wake_cnt <= wake_cnt_nxt;
            gate_en  <= (state_nxt != GATED);
            gated    <= (state_nxt == GATED);
            wake_ack <= wake_ack_nxt;
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: expected output words are queued as each step is driven
// and popped against the DUT one edge later (or immediately for asynchronous effects).
module tb_clk_gate_ctrl;

    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int W        = 16;
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_GATED = 2'd1;
    localparam logic [1:0] S_WAKE  = 2'd2;

    logic              clk;
    logic              rst;
    logic              cfg_auto_en;
    logic [IDLE_W-1:0] cfg_idle_thresh;
    logic              busy;
    logic              wake_req;
    logic              force_on;
    logic              test_mode;
    logic              gate_en;
    logic              gate_se;
    logic              gated;
    logic              wake_ack;
    logic [1:0]        dbg_state;
    logic [IDLE_W-1:0] dbg_idle_cnt;

    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    clk_gate_ctrl #(
        .IDLE_W  (IDLE_W),
        .WAKE_CYC(WAKE_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_auto_en    (cfg_auto_en),
        .cfg_idle_thresh(cfg_idle_thresh),
        .busy           (busy),
        .wake_req       (wake_req),
        .force_on       (force_on),
        .test_mode      (test_mode),
        .gate_en        (gate_en),
        .gate_se        (gate_se),
        .gated          (gated),
        .wake_ack       (wake_ack),
        .dbg_state      (dbg_state),
        .dbg_idle_cnt   (dbg_idle_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [1:0] st, input logic en, input logic gt,
                                        input logic ack, input logic se,
                                        input logic [IDLE_W-1:0] cnt);
        return {2'b00, st, en, gt, ack, se, cnt};
    endfunction

    function automatic logic [W-1:0] observe();
        return {2'b00, dbg_state, gate_en, gated, wake_ack, gate_se, dbg_idle_cnt};
    endfunction

    // scoreboard
    task automatic compare(input string tag);
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        obs = observe();
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %04h but no expected entry queued", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change #1 after an edge, outputs sampled #1 after the next edge
    task automatic expect_step(input string tag, input logic [1:0] st, input logic en,
                               input logic gt, input logic ack, input logic se,
                               input logic [IDLE_W-1:0] cnt);
        exp_q.push_back(mk(st, en, gt, ack, se, cnt));
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic expect_now(input string tag, input logic [1:0] st, input logic en,
                              input logic gt, input logic ack, input logic se,
                              input logic [IDLE_W-1:0] cnt);
        exp_q.push_back(mk(st, en, gt, ack, se, cnt));
        #1;
        compare(tag);
    endtask

    task automatic idle_steps(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        cfg_auto_en = 1'b1;
        cfg_idle_thresh = 8'd3;
        busy = 1'b0;
        wake_req = 1'b0;
        force_on = 1'b0;
        test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_now("reset_state", S_RUN, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // thresh=3: gate at the third idle edge, busy pulse wakes, two settle cycles
        expect_step("t3_idle1", S_RUN, 1, 0, 0, 0, 1);
        expect_step("t3_idle2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("t3_gate", S_GATED, 0, 1, 0, 0, 0);
        idle_steps(6);
        expect_step("t3_stay_gated", S_GATED, 0, 1, 0, 0, 0);
        busy = 1'b1;
        expect_step("busy_wake", S_WAKE, 1, 0, 0, 0, 0);
        busy = 1'b0;
        expect_step("busy_wake2", S_WAKE, 1, 0, 0, 0, 0);
        expect_step("busy_run", S_RUN, 1, 0, 0, 0, 0);
        expect_step("regate_1", S_RUN, 1, 0, 0, 0, 1);
        expect_step("regate_2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("regate_3", S_GATED, 0, 1, 0, 0, 0);

        // wake_req from GATED: one ack WAKE_CYC edges after sampling, none while held after it
        wake_req = 1'b1;
        expect_step("wreq_wake", S_WAKE, 1, 0, 0, 0, 0);
        expect_step("wreq_wake2", S_WAKE, 1, 0, 0, 0, 0);
        expect_step("wreq_ack", S_RUN, 1, 0, 1, 0, 0);
        expect_step("wreq_held_noack", S_RUN, 1, 0, 0, 0, 0);
        wake_req = 1'b0;
        expect_step("wreq_drop", S_RUN, 1, 0, 0, 0, 1);
        expect_step("wreq_drop2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("wreq_regate", S_GATED, 0, 1, 0, 0, 0);

        // thresh=5 with busy on the 4th idle cycle restarts the count
        busy = 1'b1;
        cfg_idle_thresh = 8'd5;
        expect_step("t5_wake", S_WAKE, 1, 0, 0, 0, 0);
        busy = 1'b0;
        expect_step("t5_wake2", S_WAKE, 1, 0, 0, 0, 0);
        expect_step("t5_run", S_RUN, 1, 0, 0, 0, 0);
        expect_step("t5_c1", S_RUN, 1, 0, 0, 0, 1);
        expect_step("t5_c2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("t5_c3", S_RUN, 1, 0, 0, 0, 3);
        busy = 1'b1;
        expect_step("t5_busy_clear", S_RUN, 1, 0, 0, 0, 0);
        busy = 1'b0;
        expect_step("t5_f1", S_RUN, 1, 0, 0, 0, 1);
        expect_step("t5_f2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("t5_f3", S_RUN, 1, 0, 0, 0, 3);
        expect_step("t5_f4", S_RUN, 1, 0, 0, 0, 4);
        expect_step("t5_gate", S_GATED, 0, 1, 0, 0, 0);

        // asynchronous reset while GATED, then thresh=4
        rst = 1'b1;
        cfg_idle_thresh = 8'd4;
        expect_now("rst_async", S_RUN, 1, 0, 0, 0, 0);
        expect_step("rst_held", S_RUN, 1, 0, 0, 0, 0);
        rst = 1'b0;
        expect_step("t4_c1", S_RUN, 1, 0, 0, 0, 1);
        expect_step("t4_c2", S_RUN, 1, 0, 0, 0, 2);
        expect_step("t4_c3", S_RUN, 1, 0, 0, 0, 3);
        expect_step("t4_gate", S_GATED, 0, 1, 0, 0, 0);

        // test_mode while GATED: SE follows at once, EN on the next edge
        test_mode = 1'b1;
        expect_now("tm_se_comb", S_GATED, 0, 1, 0, 1, 0);
        expect_step("tm_wake", S_WAKE, 1, 0, 0, 1, 0);
        expect_step("tm_wake2", S_WAKE, 1, 0, 0, 1, 0);
        expect_step("tm_run", S_RUN, 1, 0, 0, 1, 0);
        test_mode = 1'b0;

        // 300 idle cycles each with thresh=0, auto_en=0, force_on=1: never gates, count stays 0
        cfg_idle_thresh = 8'd0;
        for (int i = 0; i < 300; i++) expect_step("thresh0_hold", S_RUN, 1, 0, 0, 0, 0);
        cfg_idle_thresh = 8'd3;
        cfg_auto_en = 1'b0;
        for (int i = 0; i < 300; i++) expect_step("autooff_hold", S_RUN, 1, 0, 0, 0, 0);
        cfg_auto_en = 1'b1;
        force_on = 1'b1;
        for (int i = 0; i < 300; i++) expect_step("force_hold", S_RUN, 1, 0, 0, 0, 0);
        force_on = 1'b0;

        // wake_req in RUN: ack next cycle; a held request acks every other cycle
        expect_step("run_c1", S_RUN, 1, 0, 0, 0, 1);
        wake_req = 1'b1;
        expect_step("run_ack1", S_RUN, 1, 0, 1, 0, 0);
        expect_step("run_gap", S_RUN, 1, 0, 0, 0, 0);
        expect_step("run_ack2", S_RUN, 1, 0, 1, 0, 0);
        wake_req = 1'b0;
        expect_step("run_drop", S_RUN, 1, 0, 0, 0, 1);

        // thresh lowered from 200 to 2 at count 50: gates on the next idle edge
        cfg_idle_thresh = 8'd200;
        idle_steps(48);
        expect_step("t200_c50", S_RUN, 1, 0, 0, 0, 50);
        cfg_idle_thresh = 8'd2;
        expect_step("lower_gate", S_GATED, 0, 1, 0, 0, 0);

        // busy and wake_req together in GATED: one WAKE pass, one ack
        busy = 1'b1;
        wake_req = 1'b1;
        expect_step("both_wake", S_WAKE, 1, 0, 0, 0, 0);
        busy = 1'b0;
        expect_step("both_wake2", S_WAKE, 1, 0, 0, 0, 0);
        expect_step("both_ack", S_RUN, 1, 0, 1, 0, 0);
        wake_req = 1'b0;
        expect_step("both_noack", S_RUN, 1, 0, 0, 0, 1);
        expect_step("both_regate", S_GATED, 0, 1, 0, 0, 0);

        if (exp_q.size() != 0) begin
            n_err++;
            $error("FAIL leftover_queue: observed %0d entries required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
